// File: rtl/breath_pkg.sv
// Shared state encoding and parameter helpers for the breathing-LED PWM.
package breath_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_UP      = 3'd1,
    ST_HOLD_HI = 3'd2,
    ST_DOWN    = 3'd3,
    ST_HOLD_LO = 3'd4
  } breath_state_e;

  function automatic int breath_max(input int width);
    return (1 << width) - 1;
  endfunction

endpackage

// File: rtl/edge_tick.sv
// Turns the divided-clock level into a single-cycle tick on each rising edge,
// treating the level purely as data sampled by clk.
module edge_tick (
  input  logic clk,
  input  logic rst,
  input  logic level_in,
  output logic tick
);

  logic s0, s1, s2;
  logic sampled;
  logic armed;

  // armed waits for a genuine low sample after reset, so a level that is
  // already high at release cannot masquerade as a rising edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s0      <= 1'b0;
      s1      <= 1'b0;
      s2      <= 1'b0;
      sampled <= 1'b0;
      armed   <= 1'b0;
    end else begin
      s0      <= level_in;
      s1      <= s0;
      s2      <= s1;
      sampled <= 1'b1;
      if (sampled && !s0) armed <= 1'b1;
    end
  end

  assign tick = s1 && !s2 && armed;

endmodule

// File: rtl/breath_pwm.sv
// Breathing PWM: duty ramps up, holds at MAX, ramps down, holds at 0, and
// repeats; duty and state only change at the end of a PWM period.
module breath_pwm
  import breath_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int STEP  = 1,
  parameter int HOLD  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clkdiv_in,
  input  logic             en,
  output logic             pwm_out,
  output logic [WIDTH-1:0] duty,
  output logic [2:0]       phase,
  output logic             period_done
);

  localparam int                MAX_I     = breath_max(WIDTH);
  localparam logic [WIDTH-1:0]  MAX_N     = WIDTH'(MAX_I);
  localparam logic [WIDTH:0]    MAX_W     = (WIDTH+1)'(MAX_I);
  localparam logic [WIDTH-1:0]  STEP_N    = WIDTH'(STEP);
  localparam logic [WIDTH:0]    STEP_W    = (WIDTH+1)'(STEP);
  localparam int                HW        = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [HW-1:0]     HOLD_LAST = HW'((HOLD > 0) ? HOLD - 1 : 0);

  breath_state_e    state, state_n;
  logic [WIDTH-1:0] duty_n;
  logic [WIDTH-1:0] pwm_cnt;
  logic [HW-1:0]    hold_cnt, hold_n;
  logic [WIDTH:0]   up_sum;
  logic             tick;
  logic             wrap;

  edge_tick u_tick (
    .clk      (clk),
    .rst      (rst),
    .level_in (clkdiv_in),
    .tick     (tick)
  );

  assign wrap   = tick && (state != ST_IDLE) && (pwm_cnt == MAX_N);
  assign up_sum = {1'b0, duty} + STEP_W;

  always_comb begin
    state_n = state;
    duty_n  = duty;
    hold_n  = hold_cnt;
    if (!en) begin
      // Disable wins over any tick or wrap in the same cycle.
      state_n = ST_IDLE;
      duty_n  = '0;
      hold_n  = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          state_n = ST_UP;
          duty_n  = '0;
          hold_n  = '0;
        end
        ST_UP: begin
          if (wrap) begin
            if (up_sum >= MAX_W) begin
              duty_n  = MAX_N;
              hold_n  = '0;
              state_n = (HOLD == 0) ? ST_DOWN : ST_HOLD_HI;
            end else begin
              duty_n = up_sum[WIDTH-1:0];
            end
          end
        end
        ST_DOWN: begin
          if (wrap) begin
            if ({1'b0, duty} <= STEP_W) begin
              duty_n  = '0;
              hold_n  = '0;
              state_n = (HOLD == 0) ? ST_UP : ST_HOLD_LO;
            end else begin
              duty_n = duty - STEP_N;
            end
          end
        end
        ST_HOLD_HI, ST_HOLD_LO: begin
          if (wrap) begin
            if (hold_cnt == HOLD_LAST) begin
              hold_n  = '0;
              state_n = (state == ST_HOLD_HI) ? ST_DOWN : ST_UP;
            end else begin
              hold_n = hold_cnt + HW'(1);
            end
          end
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      duty     <= '0;
      hold_cnt <= '0;
    end else begin
      state    <= state_n;
      duty     <= duty_n;
      hold_cnt <= hold_n;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm_cnt     <= '0;
      period_done <= 1'b0;
    end else begin
      period_done <= en && wrap;
      if (!en || state == ST_IDLE) pwm_cnt <= '0;
      else if (tick)               pwm_cnt <= pwm_cnt + WIDTH'(1);
    end
  end

  assign pwm_out = (state != ST_IDLE) && (pwm_cnt < duty);
  assign phase   = state;

endmodule

// File: tb/tb_breath_pwm.sv
// Directed bench for breath_pwm: ramp/hold sequence, duty-cycle shape,
// enable priority, asynchronous reset and HOLD=0 alternation.
module tb_breath_pwm;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         clkdiv_in = 1'b0;
  logic         en = 1'b0;
  logic         en_b = 1'b0;
  logic         pwm_out, period_done, pwm_out_b, period_done_b;
  logic [W-1:0] duty, duty_b;
  logic [2:0]   phase, phase_b;

  int n_checks = 0;
  int n_errors = 0;
  bit div_run = 1'b0;
  int div_cnt = 0;

  logic [W-1:0] exp_q[$];

  breath_pwm #(.WIDTH(W), .STEP(5), .HOLD(2)) u_dut (
    .clk         (clk),
    .rst         (rst),
    .clkdiv_in   (clkdiv_in),
    .en          (en),
    .pwm_out     (pwm_out),
    .duty        (duty),
    .phase       (phase),
    .period_done (period_done)
  );

  breath_pwm #(.WIDTH(W), .STEP(15), .HOLD(0)) u_alt (
    .clk         (clk),
    .rst         (rst),
    .clkdiv_in   (clkdiv_in),
    .en          (en_b),
    .pwm_out     (pwm_out_b),
    .duty        (duty_b),
    .phase       (phase_b),
    .period_done (period_done_b)
  );

  // Clock and divided-clock generation; clkdiv_in moves 1 unit after posedge.
  always #5 clk = ~clk;

  always begin
    @(posedge clk);
    #1;
    if (div_run) begin
      if (div_cnt == 3) begin
        div_cnt   = 0;
        clkdiv_in = ~clkdiv_in;
      end else begin
        div_cnt++;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Starts at a negedge; returns at the negedge where period_done is seen.
  task automatic run_period(output int cyc, output int hi, output bit ok);
    cyc = 0;
    hi  = 0;
    ok  = 1'b0;
    for (int i = 0; i < 400; i++) begin
      hi += int'(pwm_out);
      cyc++;
      @(negedge clk);
      if (period_done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_alt_pd(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (period_done_b) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  int ramp_duty[11]  = '{5, 10, 15, 15, 15, 10, 5, 0, 0, 0, 5};
  int ramp_phase[11] = '{1, 1, 2, 2, 3, 3, 3, 4, 4, 1, 1};
  int alt_duty[3]    = '{15, 0, 15};
  int alt_phase[3]   = '{3, 1, 3};

  initial begin
    int cyc, hi, prev, cnt;
    bit ok;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_phase", 32'(phase), 0);
    check("rst_duty", 32'(duty), 0);
    check("rst_pwm", 32'(pwm_out), 0);
    check("rst_pd", 32'(period_done), 0);
    rst = 1'b0;
    div_run = 1'b1;
    repeat (2) @(negedge clk);

    // Enable: IDLE -> UP on the next edge with duty 0
    en = 1'b1;
    @(negedge clk);
    check("start_phase", 32'(phase), 1);
    check("start_duty", 32'(duty), 0);
    check("start_pwm", 32'(pwm_out), 0);

    // Full ramp/hold cycle with period shape checks
    foreach (ramp_duty[k]) exp_q.push_back(W'(ramp_duty[k]));
    prev = 0;
    for (int k = 0; k < 11; k++) begin
      logic [W-1:0] e;
      run_period(cyc, hi, ok);
      check($sformatf("ramp_timeout%0d", k), 32'(ok), 1);
      if (!ok) break;
      e = exp_q.pop_front();
      check($sformatf("ramp_duty%0d", k), 32'(duty), 32'(e));
      check($sformatf("ramp_phase%0d", k), 32'(phase), 32'(ramp_phase[k]));
      if (k > 0) begin
        check($sformatf("ramp_len%0d", k), 32'(cyc), 128);
        check($sformatf("ramp_high%0d", k), 32'(hi), 32'(prev * 8));
      end
      prev = int'(e);
    end

    // Drop en mid-UP at duty 10, then restart the ramp
    run_period(cyc, hi, ok);
    check("drop_pre_timeout", 32'(ok), 1);
    check("drop_pre_duty", 32'(duty), 10);
    repeat (40) @(negedge clk);
    check("drop_pre_pwm", 32'(pwm_out), 1);
    en = 1'b0;
    @(negedge clk);
    check("drop_phase", 32'(phase), 0);
    check("drop_duty", 32'(duty), 0);
    check("drop_pwm", 32'(pwm_out), 0);
    repeat (5) @(negedge clk);
    en = 1'b1;
    @(negedge clk);
    run_period(cyc, hi, ok);
    check("restart_timeout", 32'(ok), 1);
    check("restart_duty", 32'(duty), 5);
    check("restart_phase", 32'(phase), 1);

    // en low in the very cycle of the wrap tick
    repeat (127) @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    check("wrapdrop_phase", 32'(phase), 0);
    check("wrapdrop_duty", 32'(duty), 0);
    check("wrapdrop_pd", 32'(period_done), 0);

    // Async reset in HOLD_HI, clkdiv held high across release
    repeat (3) @(negedge clk);
    en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      run_period(cyc, hi, ok);
      check($sformatf("hold_timeout%0d", k), 32'(ok), 1);
    end
    check("hold_duty", 32'(duty), 15);
    check("hold_phase", 32'(phase), 2);
    repeat (30) @(negedge clk);
    check("hold_pwm", 32'(pwm_out), 1);
    #2;
    div_run   = 1'b0;
    clkdiv_in = 1'b1;
    rst       = 1'b1;
    #1;
    check("arst_phase", 32'(phase), 0);
    check("arst_duty", 32'(duty), 0);
    check("arst_pwm", 32'(pwm_out), 0);
    check("arst_pd", 32'(period_done), 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("rel_phase", 32'(phase), 1);
    clkdiv_in = 1'b0;
    div_cnt   = 0;
    div_run   = 1'b1;
    cnt = 0;
    ok  = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      cnt++;
      if (period_done) begin
        ok = 1'b1;
        break;
      end
    end
    check("rearm_timeout", 32'(ok), 1);
    check("rearm_cycles", 32'(cnt), 127);
    check("rearm_duty", 32'(duty), 5);

    // HOLD=0, STEP=15 instance alternates between the extremes
    en   = 1'b0;
    en_b = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_alt_pd(ok);
      check($sformatf("alt_timeout%0d", k), 32'(ok), 1);
      if (!ok) break;
      check($sformatf("alt_duty%0d", k), 32'(duty_b), 32'(alt_duty[k]));
      check($sformatf("alt_phase%0d", k), 32'(phase_b), 32'(alt_phase[k]));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/breath_pwm.md
BREATH_PWM -- requirements
Module: breath_pwm

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 The block SHALL have parameter WIDTH, default 8, giving the PWM resolution in bits; MAX = 2^WIDTH-1.
REQ-003 The block SHALL have parameter STEP, default 1, giving the duty increment or decrement per PWM period; legal range 1..MAX.
REQ-004 The block SHALL have parameter HOLD, default 16, giving the number of PWM periods spent at each extreme; 0 means no hold.
REQ-005 The block SHALL have port clk, input, 1 bit: system clock.
REQ-006 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-007 The block SHALL have port clkdiv_in, input, 1 bit: divided-clock level from the upstream divider, treated as data and never used as a clock.
REQ-008 The block SHALL have port en, input, 1 bit: run enable, synchronous to clk.
REQ-009 The block SHALL have port pwm_out, output, 1 bit: PWM waveform.
REQ-010 The block SHALL have port duty, output, WIDTH bits: current duty value.
REQ-011 The block SHALL have port phase, output, 3 bits: current FSM state encoding.
REQ-012 The block SHALL have port period_done, output, 1 bit: one-cycle pulse at each PWM period end.

Function
REQ-013 The block SHALL turn clkdiv_in into a one-clk-cycle tick via a 3-flop shift s0, s1, s2, with tick = s1 AND NOT s2; tick is high in the cycle after the 2nd clk edge that samples clkdiv_in high.
REQ-014 pwm_cnt (WIDTH bits) SHALL increment by 1 only on a tick while state is not IDLE, wrapping from MAX to 0.
REQ-015 period_done SHALL be high for exactly one cycle, in the cycle after a tick that wraps pwm_cnt from MAX to 0.
REQ-016 pwm_out SHALL equal (state is not IDLE) AND (pwm_cnt < duty), so duty 0 gives a constant 0 and duty MAX gives low only at cnt = MAX.
REQ-017 Duty and the FSM SHALL update only at the wrap tick, so there is never a mid-period duty change.
REQ-018 The FSM SHALL have the states IDLE=0, UP=1, HOLD_HI=2, DOWN=3, HOLD_LO=4.
REQ-019 IDLE SHALL go to UP on the cycle after en is sampled high, with duty = 0 and pwm_cnt = 0.
REQ-020 UP, at a wrap: if duty + STEP >= MAX, the block SHALL set duty = MAX and go to HOLD_HI, or to DOWN if HOLD = 0; otherwise duty += STEP.
REQ-021 DOWN, at a wrap: if duty <= STEP, the block SHALL set duty = 0 and go to HOLD_LO, or to UP if HOLD = 0; otherwise duty -= STEP.
REQ-022 HOLD_HI and HOLD_LO SHALL count wraps in hold_cnt, cleared on entry; at the wrap where hold_cnt = HOLD-1, they go to DOWN and UP respectively.
REQ-023 Duty arithmetic SHALL use WIDTH+1 bits internally so it never overflows or underflows.
REQ-024 en sampled low in any state SHALL force IDLE on the next edge and clear duty, pwm_cnt and hold_cnt; en low takes priority over a simultaneous tick or wrap.
REQ-025 phase SHALL reflect the registered state.

Reset
REQ-026 While rst is high, the block SHALL set state = IDLE and clear pwm_cnt, duty, hold_cnt, s0, s1, s2, pwm_out and period_done, independent of clk.
REQ-027 After rst deasserts, the first tick SHALL need a fresh rising edge of clkdiv_in; a level already high at release SHALL NOT create a tick.

Structure
REQ-028 The state encoding and a MAX-derivation function SHALL reside in a shared package, breath_pkg.
REQ-029 Tick generation SHALL be one sub-module, edge_tick (ports clk, rst, level_in, tick); the rest is a single always block for the FSM and duty plus one for pwm_cnt.

Verification
REQ-030 Use WIDTH=4, STEP=5, HOLD=2, with clkdiv_in toggling every 4 clk; en rises -> duty sequence at successive period_done: 5, 10, 15, 15, 15, 10, 5, 0, 0, 0, 5.
REQ-031 With duty=10 in a steady period -> pwm_out high for exactly 10 of 16 ticks per period.
REQ-032 Drop en mid-UP with duty=10 -> next cycle phase=0, duty=0, pwm_out=0; re-raise en -> ramp restarts at 5 after the first period.
REQ-033 Set en low on the same cycle as a wrap tick -> IDLE reached and duty=0, with no duty update.
REQ-034 Assert rst asynchronously mid-HOLD_HI, between clk edges -> all outputs 0 immediately; hold clkdiv_in high across release -> no tick until the next rising edge.
REQ-035 Use HOLD=0, STEP=15 -> duty alternates 15, 0, 15 on each period_done.
